// File: rtl/wb_reg_encoder_if.sv
// ---------------------------------------------------------------------------
// wb_reg_encoder_if
//   Bundle between the register-file write-back request sources, the encoder
//   and the write-port control.
//
//   req_set   : per-register write-back request pulses (bit 0 is ignored)
//   flush     : synchronous clear of all pending requests and of the output
//   wr_ready  : write-port control accepts wr_id this cycle
//   wr_valid  : wr_id names a pending register
//   wr_id     : encoded register ID
//   wr_onehot : one-hot decode of wr_id, all zero while wr_valid=0
//   pending   : registered pending vector
//
//   Handshake: wr_valid/wr_id are launched from flops. Once wr_valid is high,
//   wr_id stays stable until the cycle in which wr_ready is also high. That
//   cycle is the transfer (accept). wr_ready may toggle freely and carries no
//   meaning while wr_valid is low.
//
//   master : request side and write-port control (drives req_set, flush, wr_ready)
//   slave  : the encoder
// ---------------------------------------------------------------------------
interface wb_reg_encoder_if #(
    parameter int NUM_REGS = 16,
    parameter int ID_W     = 4
);
    logic [NUM_REGS-1:0] req_set;
    logic                flush;
    logic                wr_ready;
    logic                wr_valid;
    logic [ID_W-1:0]     wr_id;
    logic [NUM_REGS-1:0] wr_onehot;
    logic [NUM_REGS-1:0] pending;

    modport master (
        output req_set, flush, wr_ready,
        input  wr_valid, wr_id, wr_onehot, pending
    );

    modport slave (
        input  req_set, flush, wr_ready,
        output wr_valid, wr_id, wr_onehot, pending
    );
endinterface

// File: rtl/wb_reg_encoder.sv
// ---------------------------------------------------------------------------
// wb_reg_encoder
//   Write-back request encoder for the 16-entry register file. Per-register
//   request pulses are collected into a pending vector. One pending register
//   per transaction is chosen round-robin, encoded to a register ID and
//   offered on a valid/ready port. Register 0 is hardwired zero and can
//   never become pending.
//
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : wb_reg_encoder_if.slave (req_set, flush, wr_ready in;
//             wr_valid, wr_id, wr_onehot, pending out)
//
//   NUM_REGS must equal 2**ID_W. The pointer arithmetic relies on natural
//   ID_W-bit wrap-around.
// ---------------------------------------------------------------------------
module wb_reg_encoder #(
    parameter int NUM_REGS = 16,
    parameter int ID_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_reg_encoder_if.slave       bus
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] grant_mask;
    logic [NUM_REGS-1:0] cand_vec;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     wr_id_q;
    logic [ID_W-1:0]     cand_id;
    logic [ID_W-1:0]     idx;
    logic                wr_valid_q;
    logic                cand_found;
    logic                accept;

    assign accept = wr_valid_q & bus.wr_ready;

    // One-hot of the ID being transferred this cycle (zero when no transfer).
    always_comb begin
        grant_mask = '0;
        if (accept) begin
            grant_mask[wr_id_q] = 1'b1;
        end
    end

    // The register leaving this cycle must not be picked again immediately.
    // Same-cycle req_set bits are deliberately not visible here.
    assign cand_vec = pending_q & ~grant_mask;

    // Round-robin search starting just past ptr. When k reaches NUM_REGS the
    // ID_W-bit sum wraps back to ptr itself, so every entry is visited once.
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        idx        = '0;
        for (int k = 1; k <= NUM_REGS; k++) begin
            idx = ptr_q + ID_W'(k);
            if (!cand_found && cand_vec[idx]) begin
                cand_found = 1'b1;
                cand_id    = idx;
            end
        end
    end

    // A set in the same cycle as the accept of that bit keeps it pending,
    // because req_set is ORed after the accept clear.
    always_comb begin
        pending_d = pending_q;
        if (bus.flush) begin
            pending_d = '0;
        end else begin
            pending_d    = bus.req_set | (pending_q & ~grant_mask);
            pending_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_id_q    <= '0;
            ptr_q      <= ID_W'(NUM_REGS - 1);
        end else begin
            pending_q <= pending_d;
            if (bus.flush) begin
                // Flush drops the offer but keeps wr_id and ptr.
                wr_valid_q <= 1'b0;
            end else begin
                if (accept) begin
                    ptr_q <= wr_id_q;
                end
                // Load a new offer only when the output is idle or just
                // transferred. Otherwise hold it stable under backpressure.
                if (!wr_valid_q || accept) begin
                    wr_valid_q <= cand_found;
                    if (cand_found) begin
                        wr_id_q <= cand_id;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.wr_onehot = '0;
        if (wr_valid_q) begin
            bus.wr_onehot[wr_id_q] = 1'b1;
        end
    end

    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_id    = wr_id_q;
    assign bus.pending  = pending_q;

endmodule

// File: doc/wb_reg_encoder.md
Name: wb_reg_encoder

Overview:
- Write-back request encoder for the 16-entry register file. It is the opposite direction of the read-side 4:16 wordline decoder.
- Collects per-register write-back requests as a 16-bit pending vector and selects one pending register per transaction, round-robin.
- Encodes the selected register to a 4-bit register ID and presents it on a valid/ready port to the write-port control. The one-hot form is provided as a cross-check.
- Register 0 is hardwired zero and is never requested.

Parameters:
- NUM_REGS, 16, number of register entries. Must equal 2**ID_W.
- ID_W, 4, register ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_set  in  NUM_REGS  per-register request pulses. Bit i set for one cycle marks register i pending.
- flush  in  1  synchronous clear of all pending requests and of the output.
- wr_ready  in  1  consumer accepts wr_id this cycle.
- wr_valid  out  1  wr_id holds a valid pending register.
- wr_id  out  ID_W  encoded register ID.
- wr_onehot  out  NUM_REGS  one-hot decode of wr_id, gated by wr_valid. All zero when wr_valid=0.
- pending  out  NUM_REGS  current pending vector, registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pending=0, wr_valid=0, wr_id=0, wr_onehot=0.
  - Round-robin pointer ptr=NUM_REGS-1, so the first search starts at ID 0.
  - Reset takes effect immediately, mid-transaction included. No state survives.
- accept = wr_valid & wr_ready.
- pending update, per bit i, at each rising edge:
  - flush=1: all pending bits go to 0. Flush wins over everything.
  - Otherwise, for i≠0: pending[i] <= req_set[i] | (pending[i] & ~(accept & wr_id==i)).
    - A set arriving in the same cycle as the accept of that ID keeps the bit pending, so the ID is re-granted later.
    - A set while the bit is already pending merges: there is no counting.
  - req_set[0] is ignored, so pending[0] is always 0.
- Candidate selection (combinational):
  - Source vector cand_vec = pending & ~(accept ? onehot(wr_id) : 0).
  - Same-cycle req_set bits are not visible to selection.
  - Search cand_vec from (ptr+1) mod NUM_REGS upward, wrapping. The first set bit is the candidate.
- Output register:
  - flush=1: wr_valid <= 0. wr_id holds. ptr unchanged.
  - Else if wr_valid=0 or accept=1:
    - If a candidate exists: wr_valid <= 1, wr_id <= candidate.
    - If no candidate: wr_valid <= 0, wr_id holds.
  - Else (wr_valid=1, wr_ready=0): wr_valid and wr_id hold stable, even if other requests arrive.
  - On accept: ptr <= wr_id.
- Latency:
  - req_set at edge k sets pending at edge k.
  - wr_valid asserts at edge k+1 if the output is idle.
  - Back-to-back accepts: with wr_ready held at 1, one ID is granted per cycle with no bubbles.
- Throughput: at most one grant per clock. A fully pending vector drains in 15 consecutive cycles.
- Invariant: wr_valid=1 implies pending[wr_id]=1 and wr_id≠0.
- Width rule: ptr and wr_id wrap modulo NUM_REGS. No out-of-range ID is produced.

Test Plan:
- Reset: assert rst_n=0 mid-stream with wr_valid=1 and pending=0x00F0 -> immediately wr_valid=0, wr_id=0, pending=0. After release, idle until the next req_set.
- Basic encode: req_set=0x0024 for 1 cycle, wr_ready=1 ->
  - cycle+1: wr_valid=1, wr_id=2, wr_onehot=0x0004.
  - cycle+2: wr_id=5, wr_onehot=0x0020.
  - cycle+3: wr_valid=0, pending=0.
- Backpressure / round-robin wrap:
  - Pend ID 5 with wr_ready=0; wr_id=5 holds for 10 cycles while req_set=0x0008 arrives.
  - Raise wr_ready -> ID 5 accepted, ptr=5, next wr_id=3 (search from 6 wraps to 3).
- Fairness: set pending=0xFFFE and re-pulse each accepted bit on its accept cycle, with wr_ready=1 -> grant order 1,2,...,15,1,2; no ID is starved; pending remains 0xFFFE.
- R0 and merge:
  - req_set=0x0001 -> pending stays 0 and wr_valid never asserts.
  - req_set bit 7 pulsed twice while ID 7 is pending but not yet granted -> exactly one grant of 7.
- Flush: pending=0x0F00, wr_valid=1 (wr_id=8), flush=1 together with req_set=0x0002 -> next cycle wr_valid=0, pending=0 (the set is dropped). The following request is granted normally.
